// File: rtl/video_pixel_serialiser_if.sv
// Byte-stream handshake into the pixel serialiser.
// The source drives data/valid; the serialiser answers with ready.
interface video_pixel_serialiser_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              data_ready;

    modport master (
        output data,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/video_pixel_serialiser.sv
// VDG pixel serialiser: one-deep byte buffer, MSB-first unpack to
// 1/2/4 bpp at clk/1..clk/8, with blank substitution on underrun.
module video_pixel_serialiser #(
    parameter int DATA_W = 8,
    parameter int PIX_W  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable_i,
    input  logic [1:0]       mode_i,
    input  logic [1:0]       div_sel_i,
    input  logic             clr_underrun_i,
    video_pixel_serialiser_if.slave in_if,
    output logic [PIX_W-1:0] pixel_o,
    output logic             pixel_strobe_o,
    output logic             underrun_o
);
    localparam int CW = $clog2(DATA_W + 1);

    // bpp code: 0 = 1bpp, 1 = 2bpp, 2 = 4bpp
    logic [1:0]        bpp_q, bpp_d;
    logic [2:0]        dcnt_q, dcnt_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PIX_W-1:0]  pixel_q, pixel_d;
    logic              strobe_q, strobe_d;
    logic              underrun_q, underrun_d;

    logic [2:0] term;
    logic [1:0] mode_code;
    logic       tick;
    logic       set_ur;

    function automatic logic [PIX_W-1:0] top_bits(
        input logic [DATA_W-1:0] v,
        input logic [1:0]        c
    );
        logic [PIX_W-1:0] r;
        r = '0;
        case (c)
            2'd0:    r = PIX_W'(v[DATA_W-1]);
            2'd1:    r = PIX_W'(v[DATA_W-1 -: 2]);
            default: r = PIX_W'(v[DATA_W-1 -: 4]);
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] shl(
        input logic [DATA_W-1:0] v,
        input logic [1:0]        c
    );
        logic [DATA_W-1:0] r;
        r = '0;
        case (c)
            2'd0:    r = v << 1;
            2'd1:    r = v << 2;
            default: r = v << 4;
        endcase
        return r;
    endfunction

    function automatic logic [CW-1:0] load_cnt(input logic [1:0] c);
        logic [CW-1:0] r;
        r = '0;
        case (c)
            2'd0:    r = CW'(DATA_W - 1);
            2'd1:    r = CW'(DATA_W / 2 - 1);
            default: r = CW'(DATA_W / 4 - 1);
        endcase
        return r;
    endfunction

    always_comb begin
        term = 3'd0;
        case (div_sel_i)
            2'd0:    term = 3'd0;
            2'd1:    term = 3'd1;
            2'd2:    term = 3'd3;
            default: term = 3'd7;
        endcase
        mode_code = 2'd1;
        case (mode_i)
            2'b00:   mode_code = 2'd0;
            2'b10:   mode_code = 2'd2;
            default: mode_code = 2'd1;
        endcase
    end

    // >= so that lowering div_sel mid-count still ticks promptly
    assign tick = enable_i && (dcnt_q >= term);

    always_comb begin
        bpp_d       = bpp_q;
        dcnt_d      = dcnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        pixel_d     = pixel_q;
        strobe_d    = 1'b0;
        set_ur      = 1'b0;

        if (in_if.data_valid && !hold_full_q) begin
            hold_d      = in_if.data;
            hold_full_d = 1'b1;
        end

        if (!enable_i) begin
            dcnt_d  = '0;
            cnt_d   = '0;
            pixel_d = '0;
        end else if (!tick) begin
            dcnt_d = dcnt_q + 3'd1;
        end else begin
            dcnt_d   = '0;
            strobe_d = 1'b1;
            if (cnt_q != '0) begin
                pixel_d = top_bits(sr_q, bpp_q);
                sr_d    = shl(sr_q, bpp_q);
                cnt_d   = cnt_q - CW'(1);
            end else if (hold_full_q) begin
                // mode is sampled only at byte boundaries
                bpp_d       = mode_code;
                pixel_d     = top_bits(hold_q, mode_code);
                sr_d        = shl(hold_q, mode_code);
                cnt_d       = load_cnt(mode_code);
                hold_full_d = 1'b0;
            end else begin
                pixel_d = '0;
                set_ur  = 1'b1;
            end
        end

        underrun_d = underrun_q;
        if (set_ur) begin
            underrun_d = 1'b1;
        end else if (clr_underrun_i) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bpp_q       <= 2'd0;
            dcnt_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sr_q        <= '0;
            cnt_q       <= '0;
            pixel_q     <= '0;
            strobe_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            bpp_q       <= bpp_d;
            dcnt_q      <= dcnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            pixel_q     <= pixel_d;
            strobe_q    <= strobe_d;
            underrun_q  <= underrun_d;
        end
    end

    assign in_if.data_ready = ~hold_full_q;
    assign pixel_o          = pixel_q;
    assign pixel_strobe_o   = strobe_q;
    assign underrun_o       = underrun_q;
endmodule

// File: tb/tb_video_pixel_serialiser.sv
// Directed bench for video_pixel_serialiser: checks the pixel
// sequences, handshake, underrun flag and async reset behaviour.
module tb_video_pixel_serialiser;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [1:0] mode;
    logic [1:0] div_sel;
    logic       clr_ur;
    logic [3:0] pixel;
    logic       strobe;
    logic       underrun;

    int n_cmp = 0;
    int n_err = 0;

    video_pixel_serialiser_if #(.DATA_W(8)) bus ();

    video_pixel_serialiser #(.DATA_W(8), .PIX_W(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable_i       (enable),
        .mode_i         (mode),
        .div_sel_i      (div_sel),
        .clr_underrun_i (clr_ur),
        .in_if          (bus.slave),
        .pixel_o        (pixel),
        .pixel_strobe_o (strobe),
        .underrun_o     (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // assumes enable=0 and an empty hold buffer
    task automatic load_byte(input logic [7:0] b);
        bus.data       = b;
        bus.data_valid = 1'b1;
        step();
        bus.data_valid = 1'b0;
    endtask

    task automatic expect_px(input string tag, input logic [3:0] p);
        step();
        chk({tag, " pixel"}, 32'(pixel), 32'(p));
        chk({tag, " strobe"}, 32'(strobe), 32'd1);
    endtask

    logic [3:0] t1 [4] = '{4'h2, 4'h3, 4'h1, 4'h0};
    logic [3:0] t3 [4] = '{4'h3, 4'hC, 4'h7, 4'hE};
    logic [3:0] t6 [4] = '{4'h0, 4'h1, 4'h2, 4'h3};
    logic [7:0] a5;

    initial begin
        reset_n        = 1'b0;
        enable         = 1'b0;
        mode           = 2'b01;
        div_sel        = 2'd0;
        clr_ur         = 1'b0;
        bus.data       = '0;
        bus.data_valid = 1'b0;
        #23;
        chk("rst pixel", 32'(pixel), 0);
        chk("rst strobe", 32'(strobe), 0);
        chk("rst underrun", 32'(underrun), 0);
        chk("rst ready", 32'(bus.data_ready), 1);
        step();
        reset_n = 1'b1;
        step();

        // T1: 2bpp, clk/1, 0xB4
        load_byte(8'hB4);
        chk("t1 ready low", 32'(bus.data_ready), 0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) expect_px("t1", t1[i]);
        enable = 1'b0;
        step();
        chk("t1 off pixel", 32'(pixel), 0);
        chk("t1 off strobe", 32'(strobe), 0);
        chk("t1 underrun", 32'(underrun), 0);

        // T2: 1bpp, clk/2, 0xA5
        mode    = 2'b00;
        div_sel = 2'd1;
        load_byte(8'hA5);
        enable = 1'b1;
        a5     = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t2 gap strobe", 32'(strobe), 0);
            if (i > 0) chk("t2 hold pixel", 32'(pixel), 32'(a5[8-i]));
            step();
            chk("t2 pixel", 32'(pixel), 32'(a5[7-i]));
            chk("t2 strobe", 32'(strobe), 1);
        end
        enable = 1'b0;
        step();

        // T3: 4bpp back-to-back bytes, valid held
        mode           = 2'b10;
        div_sel        = 2'd0;
        bus.data       = 8'h3C;
        bus.data_valid = 1'b1;
        step();
        bus.data = 8'h7E;
        enable   = 1'b1;
        expect_px("t3", t3[0]);
        expect_px("t3", t3[1]);
        bus.data_valid = 1'b0;
        expect_px("t3", t3[2]);
        expect_px("t3", t3[3]);
        chk("t3 underrun", 32'(underrun), 0);
        enable = 1'b0;
        step();
        chk("t3 underrun off", 32'(underrun), 0);

        // T4: underrun after one 2bpp byte
        mode = 2'b01;
        load_byte(8'hFF);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) expect_px("t4", 4'h3);
        chk("t4 no underrun yet", 32'(underrun), 0);
        expect_px("t4 blank", 4'h0);
        chk("t4 underrun", 32'(underrun), 1);
        clr_ur = 1'b1;
        step();
        chk("t4 set beats clr", 32'(underrun), 1);
        enable = 1'b0;
        step();
        chk("t4 cleared", 32'(underrun), 0);
        clr_ur = 1'b0;
        step();

        // T5: mode change mid-byte takes effect at next byte
        mode = 2'b01;
        load_byte(8'hE4);
        enable = 1'b1;
        expect_px("t5a", 4'h3);
        expect_px("t5a", 4'h2);
        mode           = 2'b00;
        bus.data       = 8'h80;
        bus.data_valid = 1'b1;
        expect_px("t5a", 4'h1);
        bus.data_valid = 1'b0;
        expect_px("t5a", 4'h0);
        expect_px("t5b", 4'h1);
        for (int i = 0; i < 7; i++) expect_px("t5b", 4'h0);
        chk("t5 underrun", 32'(underrun), 0);
        enable = 1'b0;
        step();

        // T6: async reset mid-byte
        mode = 2'b01;
        load_byte(8'hB4);
        enable = 1'b1;
        expect_px("t6 pre", 4'h2);
        bus.data       = 8'hFF;
        bus.data_valid = 1'b1;
        expect_px("t6 pre", 4'h3);
        bus.data_valid = 1'b0;
        chk("t6 ready pre", 32'(bus.data_ready), 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6 rst pixel", 32'(pixel), 0);
        chk("t6 rst ready", 32'(bus.data_ready), 1);
        chk("t6 rst strobe", 32'(strobe), 0);
        enable = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        load_byte(8'h1B);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) expect_px("t6 post", t6[i]);
        enable = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
